// File: rtl/frame_scanout_pkg.sv
// Shared definitions for the frame buffer scan-out path: default VGA timing,
// buffer address layout and the address packing helper used by both the
// rasterizer write side and the scan-out read side.
package frame_scanout_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Buffer coordinates: x fills 10 bits, y fills 9 bits; the vertical
    // counter needs one extra bit to reach the end of the blanking interval.
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int V_CNT_W  = 10;
    localparam int ADDR_W   = X_W + Y_W;
    localparam int COLOR_W  = 12;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_t;

    // Buffer word address is the concatenation {x, y}; the writer uses the
    // same helper so both sides always agree on the layout.
    function automatic logic [ADDR_W-1:0] pack_buf_addr(input logic [X_W-1:0] x,
                                                        input logic [Y_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/frame_scanout_timing.sv
// Pixel divider plus horizontal/vertical scan counters. Produces the pixel
// tick, the active-area flag and the sync-window compares for the output stage.
module scan_timing
    import frame_scanout_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int PIX_DIV  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               run,
    output logic               tick,
    output logic [X_W-1:0]     hc,
    output logic [V_CNT_W-1:0] vc,
    output logic               active,
    output logic               h_sync_zone,
    output logic               v_sync_zone,
    output logic               frame_wrap
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(PIX_DIV);

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [X_W-1:0]     H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]     H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]     HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]     HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;

    assign tick        = run && (div == DIV_LAST);
    assign active      = (hc < H_ACT) && (vc < V_ACT);
    assign h_sync_zone = (hc >= HS_START) && (hc < HS_END);
    assign v_sync_zone = (vc >= VS_START) && (vc < VS_END);
    assign frame_wrap  = tick && (hc == H_LAST) && (vc == V_LAST);

    // Divider and raster counters; cleared whenever the scan is not running
    // so a restart always begins at pixel (0,0) with a full pixel period.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div <= '0;
            hc  <= '0;
            vc  <= '0;
        end else if (run) begin
            if (tick) begin
                div <= '0;
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// Read-side engine for the 1-bit frame buffer: drives the buffer read port in
// raster order and turns the returned bits into aligned VGA pixels and syncs.
module frame_scanout
    import frame_scanout_pkg::*;
#(
    parameter int                 H_ACTIVE = VGA_H_ACTIVE,
    parameter int                 H_FP     = VGA_H_FP,
    parameter int                 H_SYNC   = VGA_H_SYNC,
    parameter int                 H_BP     = VGA_H_BP,
    parameter int                 V_ACTIVE = VGA_V_ACTIVE,
    parameter int                 V_FP     = VGA_V_FP,
    parameter int                 V_SYNC   = VGA_V_SYNC,
    parameter int                 V_BP     = VGA_V_BP,
    parameter int                 PIX_DIV  = 2,
    parameter int                 RD_LAT   = 1,
    parameter logic [COLOR_W-1:0] FG_COLOR = 12'hFFF,
    parameter logic [COLOR_W-1:0] BG_COLOR = 12'h000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [ADDR_W-1:0]  buf_addr,
    output logic               buf_rd_en,
    input  logic               buf_rd_data,
    output logic [COLOR_W-1:0] rgb,
    output logic               h_sync,
    output logic               v_sync,
    output logic               video_on,
    output logic [X_W-1:0]     pixel_x,
    output logic [Y_W-1:0]     pixel_y,
    output logic               frame_start,
    output logic               vblank
);

    // The read data must settle inside one pixel period, because the address
    // is only held for that long.
    if (PIX_DIV < 2) begin : g_bad_pix_div
        $error("frame_scanout: PIX_DIV must be 2 or more");
    end
    if (RD_LAT >= PIX_DIV) begin : g_bad_rd_lat
        $error("frame_scanout: RD_LAT must be less than PIX_DIV");
    end

    localparam logic [V_CNT_W-1:0] V_ACT = V_CNT_W'(V_ACTIVE);

    scan_state_t         state;
    scan_state_t         state_next;
    logic                scan;
    logic                hold;
    logic                tick;
    logic [X_W-1:0]      hc;
    logic [V_CNT_W-1:0]  vc;
    logic                active;
    logic                h_sync_zone;
    logic                v_sync_zone;
    logic                frame_wrap;

    assign scan = (state == ST_SCAN);
    assign hold = reset || !enable;

    scan_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .PIX_DIV  (PIX_DIV)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .clear       (!enable),
        .run         (scan),
        .tick        (tick),
        .hc          (hc),
        .vc          (vc),
        .active      (active),
        .h_sync_zone (h_sync_zone),
        .v_sync_zone (v_sync_zone),
        .frame_wrap  (frame_wrap)
    );

    // State register: IDLE on reset, otherwise follow the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Scan runs whenever enable is sampled high; a low enable aborts at once.
    always_comb begin
        state_next = state;
        if (enable) begin
            state_next = ST_SCAN;
        end else begin
            state_next = ST_IDLE;
        end
    end

    // Read stage: address the buffer for the whole pixel period of each
    // visible pixel, and keep the port quiet during blanking and idle.
    always_comb begin
        buf_rd_en = 1'b0;
        buf_addr  = '0;
        vblank    = 1'b0;
        if (scan) begin
            vblank = (vc >= V_ACT);
            if (active) begin
                buf_rd_en = 1'b1;
                buf_addr  = pack_buf_addr(hc, vc[Y_W-1:0]);
            end
        end
    end

    // Output stage: capture colour, syncs and coordinates on the tick so all
    // of them describe the same pixel, one pixel period behind the counters.
    always_ff @(posedge clk) begin
        if (hold) begin
            rgb      <= '0;
            h_sync   <= 1'b1;
            v_sync   <= 1'b1;
            video_on <= 1'b0;
            pixel_x  <= '0;
            pixel_y  <= '0;
        end else if (tick) begin
            rgb      <= active ? (buf_rd_data ? FG_COLOR : BG_COLOR) : '0;
            h_sync   <= !h_sync_zone;
            v_sync   <= !v_sync_zone;
            video_on <= active;
            pixel_x  <= hc;
            pixel_y  <= vc[Y_W-1:0];
        end
    end

    // Frame marker: one clock wide, raised as the counters wrap back to (0,0).
    always_ff @(posedge clk) begin
        if (hold) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
        end
    end

endmodule
